// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline hazard logic.
// Holds the register-index width, the hard-wired zero register, and the
// miss-handling state enumeration used by hazard_miss_fsm and its parent.
package pipe_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        DMISS        = 2'd1,
        IMISS        = 2'd2,
        DMISS_THEN_I = 2'd3
    } haz_state_e;

    // Register 0 is hard-wired, so it never produces a dependence.
    function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return (dst == src) && (dst != ZERO_REG);
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: bundle of pipeline status inputs and stall/flush
// controls exchanged between the pipeline and hazard_control_unit.
//   slave  modport : the hazard unit (reads status, drives controls)
//   master modport : the pipeline side (drives status, reads controls)
// With HAZ_PERF_CNT_EN defined the bundle also carries the CNT_W-bit
// performance counters cnt_load_use, cnt_branch_stall, cnt_miss_cycles.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             if_id_uses_rt;
    logic             if_id_branch;
    logic             branch_taken;
    logic [REG_W-1:0] id_ex_rd;
    logic             id_ex_write_reg;
    logic             id_ex_mem_read;
    logic [REG_W-1:0] ex_mem_rd;
    logic             ex_mem_mem_read;
    logic             icache_miss;
    logic             dcache_miss;
    logic             mem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_hold;
    logic             err_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_load_use;
    logic [CNT_W-1:0] cnt_branch_stall;
    logic [CNT_W-1:0] cnt_miss_cycles;
`endif

    modport slave (
        input  if_id_rs, if_id_rt, if_id_uses_rt, if_id_branch, branch_taken,
        input  id_ex_rd, id_ex_write_reg, id_ex_mem_read,
        input  ex_mem_rd, ex_mem_mem_read,
        input  icache_miss, dcache_miss, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
        output err_timeout
`ifdef HAZ_PERF_CNT_EN
        , output cnt_load_use, cnt_branch_stall, cnt_miss_cycles
`endif
    );

    modport master (
        output if_id_rs, if_id_rt, if_id_uses_rt, if_id_branch, branch_taken,
        output id_ex_rd, id_ex_write_reg, id_ex_mem_read,
        output ex_mem_rd, ex_mem_mem_read,
        output icache_miss, dcache_miss, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold,
        input  err_timeout
`ifdef HAZ_PERF_CNT_EN
        , input cnt_load_use, cnt_branch_stall, cnt_miss_cycles
`endif
    );

endinterface

// File: rtl/hazard_miss_fsm.sv
// hazard_miss_fsm: sequences I/D-cache miss handling and watches for refills
// that never arrive.
//   clk, rst_n               : clock, async active-low reset
//   icache_miss, dcache_miss : level miss indications
//   mem_ready                : one-cycle refill-complete pulse
//   state                    : current miss-handling state
//   err_timeout              : sticky, a miss waited MISS_TIMEOUT cycles
module hazard_miss_fsm
    import pipe_pkg::*;
#(
    parameter int MISS_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       icache_miss,
    input  logic       dcache_miss,
    input  logic       mem_ready,
    output haz_state_e state,
    output logic       err_timeout
);

    localparam int CW = $clog2(MISS_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(MISS_TIMEOUT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(MISS_TIMEOUT - 1);

    haz_state_e    state_next;
    logic [CW-1:0] wait_cnt;

    // The D-miss is always served before a pending I-miss, so a pair of
    // simultaneous misses is split into two refills in a fixed order.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (dcache_miss && icache_miss) state_next = DMISS_THEN_I;
                else if (dcache_miss)           state_next = DMISS;
                else if (icache_miss)           state_next = IMISS;
            end
            DMISS:        if (mem_ready) state_next = icache_miss ? IMISS : RUN;
            DMISS_THEN_I: if (mem_ready) state_next = IMISS;
            IMISS:        if (mem_ready) state_next = RUN;
            default:      state_next = RUN;
        endcase
    end

    // The wait counter restarts on every state change so each refill gets
    // its own budget; it saturates at the limit, while the FSM keeps waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (state != RUN && wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state != RUN && state_next == state && wait_cnt == LIMIT_M1) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush generator for the 5-stage pipeline,
// covering load-use, ID-stage branch dependences and cache-miss stalls.
//   clk, rst_n : clock, async active-low reset
//   bus        : hazard_control_unit_if.slave (status in, controls out)
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating CNT_W-bit
// counters for load-use stalls, branch stalls and miss cycles.
module hazard_control_unit
    import pipe_pkg::*;
#(
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    hazard_control_unit_if.slave  bus
);

    haz_state_e state;
    logic       err_timeout;
    logic       load_use;
    logic       br_dep;
    logic       d_hold;
    logic       i_stall;

    hazard_miss_fsm #(.MISS_TIMEOUT(MISS_TIMEOUT)) u_miss_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .icache_miss (bus.icache_miss),
        .dcache_miss (bus.dcache_miss),
        .mem_ready   (bus.mem_ready),
        .state       (state),
        .err_timeout (err_timeout)
    );

    // A branch on a load in EX stalls twice: once on the id_ex term, then
    // again on the ex_mem term once the load has moved to MEM.
    always_comb begin
        load_use = bus.id_ex_mem_read &&
                   (reg_match(bus.id_ex_rd, bus.if_id_rs) ||
                    (bus.if_id_uses_rt && reg_match(bus.id_ex_rd, bus.if_id_rt)));
        br_dep   = bus.if_id_branch &&
                   ((bus.id_ex_write_reg && reg_match(bus.id_ex_rd, bus.if_id_rs)) ||
                    (bus.ex_mem_mem_read && reg_match(bus.ex_mem_rd, bus.if_id_rs)));
        d_hold   = (state == DMISS) || (state == DMISS_THEN_I) ||
                   (state == RUN && bus.dcache_miss);
        i_stall  = (state == IMISS) || (state == RUN && bus.icache_miss);
    end

    // Causes are ranked D-miss, I-miss, data dependence; a taken branch is
    // only acted on once nothing is stalling the front end.
    always_comb begin
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_bubble = 1'b0;
        bus.pipe_hold    = 1'b0;
        if (d_hold) begin
            bus.pipe_hold   = 1'b1;
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
        end else if (i_stall || load_use || br_dep) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
        end else begin
            bus.if_id_flush = bus.branch_taken;
        end
        bus.err_timeout = err_timeout;
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_lu;
    logic [CNT_W-1:0] cnt_br;
    logic [CNT_W-1:0] cnt_miss;

    // Only the cause that actually wins priority in a cycle is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_lu   <= '0;
            cnt_br   <= '0;
            cnt_miss <= '0;
        end else begin
            if ((d_hold || i_stall) && cnt_miss != '1) begin
                cnt_miss <= cnt_miss + 1'b1;
            end else if (!(d_hold || i_stall) && load_use && cnt_lu != '1) begin
                cnt_lu <= cnt_lu + 1'b1;
            end else if (!(d_hold || i_stall) && !load_use && br_dep && cnt_br != '1) begin
                cnt_br <= cnt_br + 1'b1;
            end
        end
    end

    always_comb begin
        bus.cnt_load_use     = cnt_lu;
        bus.cnt_branch_stall = cnt_br;
        bus.cnt_miss_cycles  = cnt_miss;
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed bench for hazard_control_unit, built
// with MISS_TIMEOUT=8. Expected control vectors are queued as each step is
// driven and popped when the outputs are sampled on the falling edge.
// Vector layout: {pc_write, if_id_write, if_id_flush, id_ex_bubble,
// pipe_hold, err_timeout}.
module tb_hazard_control_unit;
    import pipe_pkg::*;

    localparam logic [5:0] RUN_V   = 6'b110000;
    localparam logic [5:0] TAKEN_V = 6'b111000;
    localparam logic [5:0] BUB_V   = 6'b000100;
    localparam logic [5:0] HOLD_V  = 6'b000010;
    localparam logic [5:0] HOLDE_V = 6'b000011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [5:0] sb_q[$];

    hazard_control_unit_if #(.CNT_W(16)) hif();

    hazard_control_unit #(.MISS_TIMEOUT(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic clearInputs();
        hif.if_id_rs = '0;        hif.if_id_rt = '0;
        hif.if_id_uses_rt = 1'b0; hif.if_id_branch = 1'b0;
        hif.branch_taken = 1'b0;  hif.id_ex_rd = '0;
        hif.id_ex_write_reg = 1'b0; hif.id_ex_mem_read = 1'b0;
        hif.ex_mem_rd = '0;       hif.ex_mem_mem_read = 1'b0;
        hif.icache_miss = 1'b0;   hif.dcache_miss = 1'b0;
        hif.mem_ready = 1'b0;
    endtask

    task automatic applyStimulus(input logic [5:0] exp);
        sb_q.push_back(exp);
    endtask

    task automatic checkOutput(input string tag);
        logic [5:0] exp;
        logic [5:0] obs;
        @(negedge clk);
        exp = sb_q.pop_front();
        obs = {hif.pc_write, hif.if_id_write, hif.if_id_flush,
               hif.id_ex_bubble, hif.pipe_hold, hif.err_timeout};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [5:0] exp);
        applyStimulus(exp);
        checkOutput(tag);
    endtask

    initial begin
        clearInputs();
        step("reset", RUN_V);
        rst_n = 1'b1;
        step("idle", RUN_V);

        // Load-use on rs, then register 0, then rt with/without uses_rt.
        hif.id_ex_mem_read = 1'b1; hif.id_ex_rd = 4'd5; hif.if_id_rs = 4'd5;
        step("lu_rs", BUB_V);
        clearInputs();
        step("lu_after", RUN_V);
        hif.id_ex_mem_read = 1'b1;
        step("lu_r0", RUN_V);
        hif.id_ex_rd = 4'd7; hif.if_id_rt = 4'd7; hif.if_id_uses_rt = 1'b1;
        step("lu_rt", BUB_V);
        hif.if_id_uses_rt = 1'b0;
        step("lu_rt_unused", RUN_V);
        clearInputs();

        // Branch on ALU result: one stall, taken ignored while stalled.
        hif.if_id_branch = 1'b1; hif.branch_taken = 1'b1;
        hif.id_ex_write_reg = 1'b1; hif.id_ex_rd = 4'd3; hif.if_id_rs = 4'd3;
        step("br_alu", BUB_V);
        hif.id_ex_write_reg = 1'b0; hif.id_ex_rd = 4'd0;
        step("br_alu_taken", TAKEN_V);
        clearInputs();

        // Branch on a load: EX term, then MEM term, then the flush.
        hif.if_id_branch = 1'b1; hif.branch_taken = 1'b1; hif.if_id_rs = 4'd4;
        hif.id_ex_write_reg = 1'b1; hif.id_ex_mem_read = 1'b1; hif.id_ex_rd = 4'd4;
        step("br_ld_ex", BUB_V);
        hif.id_ex_write_reg = 1'b0; hif.id_ex_mem_read = 1'b0; hif.id_ex_rd = 4'd0;
        hif.ex_mem_mem_read = 1'b1; hif.ex_mem_rd = 4'd4;
        step("br_ld_mem", BUB_V);
        hif.ex_mem_mem_read = 1'b0; hif.ex_mem_rd = 4'd0;
        step("br_ld_taken", TAKEN_V);
        clearInputs();

        // D-miss held 6 cycles, refill on the last, back to RUN.
        hif.dcache_miss = 1'b1;
        for (int i = 0; i < 5; i++) step("dmiss_hold", HOLD_V);
        hif.mem_ready = 1'b1;
        step("dmiss_ready", HOLD_V);
        clearInputs();
        step("dmiss_done", RUN_V);

        // mem_ready in RUN does nothing.
        hif.mem_ready = 1'b1;
        step("ready_in_run", RUN_V);
        clearInputs();
        step("ready_in_run2", RUN_V);

        // I-miss alone outranks a taken branch.
        hif.icache_miss = 1'b1; hif.branch_taken = 1'b1;
        step("imiss_run", BUB_V);
        hif.branch_taken = 1'b0;
        step("imiss_wait", BUB_V);
        hif.mem_ready = 1'b1;
        step("imiss_ready", BUB_V);
        clearInputs();
        step("imiss_done", RUN_V);

        // Simultaneous misses: D first, then I.
        hif.dcache_miss = 1'b1; hif.icache_miss = 1'b1;
        step("both_run", HOLD_V);
        step("both_dthen_i", HOLD_V);
        hif.dcache_miss = 1'b0; hif.mem_ready = 1'b1;
        step("both_dready", HOLD_V);
        hif.mem_ready = 1'b0;
        step("both_imiss", BUB_V);
        hif.mem_ready = 1'b1;
        step("both_iready", BUB_V);
        clearInputs();
        step("both_done", RUN_V);

        // D-miss finishing while an I-miss is pending goes to IMISS.
        hif.dcache_miss = 1'b1;
        step("d_then_i_run", HOLD_V);
        hif.icache_miss = 1'b1; hif.mem_ready = 1'b1;
        step("d_then_i_ready", HOLD_V);
        hif.dcache_miss = 1'b0; hif.mem_ready = 1'b0;
        step("d_then_i_imiss", BUB_V);
        hif.mem_ready = 1'b1;
        step("d_then_i_iready", BUB_V);
        clearInputs();
        step("d_then_i_done", RUN_V);

        // Timeout: 8 cycles in DMISS without refill sets the sticky error.
        hif.dcache_miss = 1'b1;
        step("to_run", HOLD_V);
        for (int i = 0; i < 8; i++) step("to_wait", HOLD_V);
        step("to_err", HOLDE_V);
        hif.dcache_miss = 1'b0;
        step("to_sticky", HOLDE_V);
        rst_n = 1'b0;
        step("to_async_rst", RUN_V);
        rst_n = 1'b1;
        step("to_after_rst", RUN_V);

`ifdef HAZ_PERF_CNT_EN
        rst_n = 1'b0;
        step("perf_rst", RUN_V);
        rst_n = 1'b1;
        hif.id_ex_mem_read = 1'b1; hif.id_ex_rd = 4'd2; hif.if_id_rs = 4'd2;
        for (int i = 0; i < 3; i++) step("perf_lu", BUB_V);
        clearInputs();
        hif.dcache_miss = 1'b1;
        for (int i = 0; i < 3; i++) step("perf_dmiss", HOLD_V);
        hif.mem_ready = 1'b1;
        step("perf_dready", HOLD_V);
        clearInputs();
        step("perf_idle", RUN_V);
        checks++;
        assert (hif.cnt_load_use === 16'd3) else begin
            errors++;
            $error("[TB] FAIL cnt_load_use: observed=%0d expected=3", hif.cnt_load_use);
        end
        checks++;
        assert (hif.cnt_miss_cycles === 16'd4) else begin
            errors++;
            $error("[TB] FAIL cnt_miss_cycles: observed=%0d expected=4", hif.cnt_miss_cycles);
        end
        checks++;
        assert (hif.cnt_branch_stall === 16'd0) else begin
            errors++;
            $error("[TB] FAIL cnt_branch_stall: observed=%0d expected=0", hif.cnt_branch_stall);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
